cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: NREQ, default 3, number of result requesters (0=ALU, 1=branch/jalr unit, 2=load/store unit).
REQ-002 Parameter: QDEPTH, default 2, per-requester result queue depth.
REQ-003 Port: clk_in  input  1  system clock; the only clock.
REQ-004 Port: rst_in  input  1  reset, synchronous, active-high.
REQ-005 Port: rdy_in  input  1  global ready; when low, all state holds.
REQ-006 Port: _clear  input  1  mispredict flush from the reorder buffer.
REQ-007 Port: _req_valid  input  NREQ  per-requester result push strobe.
REQ-008 Port: _req_rob_id  input  5*NREQ  per-requester ROB id, 1..31.
REQ-009 Port: _req_value  input  32*NREQ  per-requester result value.
REQ-010 Port: _req_full  output  NREQ  per-requester queue full; the requester must not push while high.
REQ-011 Port: _cdb_ready  output  1  registered CDB broadcast valid.
REQ-012 Port: _cdb_rob_id  output  5  registered broadcast ROB id.
REQ-013 Port: _cdb_value  output  32  registered broadcast value.

Function
REQ-014 Each requester owns one FIFO of QDEPTH entries {rob_id, value}; a push is captured at the clock edge when _req_valid[i]=1, _req_full[i]=0 and rdy_in=1.
REQ-015 A push with rob_id=0 shall be dropped without changing any state.
REQ-016 _req_full[i] shall be high when count[i]==QDEPTH or rdy_in=0; it depends only on registered count and rdy_in, never on same-cycle pops.
REQ-017 Each cycle with rdy_in=1 and _clear=0, the arbiter shall select one non-empty FIFO round-robin: search starts at (last_grant+1) mod NREQ.
REQ-018 The selected FIFO head shall be popped, loaded into {_cdb_rob_id,_cdb_value}, and _cdb_ready set to 1 at that edge; last_grant takes the selected index.
REQ-019 When no FIFO is non-empty, _cdb_ready shall be 0 at the next edge; _cdb_rob_id/_cdb_value hold.
REQ-020 Latency: a push at edge t shall be broadcast no earlier than cycle t+2; an uncontended result is broadcast exactly at t+2.
REQ-021 Simultaneous push and pop on the same FIFO shall leave count unchanged and preserve FIFO order.
REQ-022 Fairness: with all NREQ FIFOs continuously non-empty, each requester shall be granted exactly once in every NREQ consecutive grants.
REQ-023 FIFO pointers shall wrap modulo QDEPTH; count ranges 0..QDEPTH.
REQ-024 _clear with rdy_in=1 shall, at that edge, empty all FIFOs, drop same-cycle pushes, set _cdb_ready=0 and last_grant=NREQ-1; no grant occurs that cycle.
REQ-025 rdy_in=0 shall freeze FIFOs, last_grant and all outputs, including _cdb_ready.
REQ-026 At most one broadcast per cycle; _cdb_ready shall never be high for two cycles carrying the same queued entry.

Reset
REQ-027 rst_in=1 at an edge shall, regardless of rdy_in, set every count and pointer to 0, last_grant=NREQ-1, _cdb_ready=0, _cdb_rob_id=0 and _cdb_value=0.
REQ-028 During and after reset, _req_full shall be 0 whenever rdy_in=1; reset mid-stream discards all queued results.

Structure
REQ-029 Shared package: the CDB payload widths (ROB id 5, value 32) and the NREQ requester index constants (ALU=0, BR=1, LS=2).
REQ-030 One sub-module, result_fifo (QDEPTH-entry, push/pop/flush, count output), shall be instantiated NREQ times.
REQ-031 The round-robin select shall be combinational inside cdb_arbiter; all outputs shall be registered.

Verification
REQ-032 Single push: req0 {id=5, val=0x1234} at edge t -> _cdb_ready=1, id=5, val=0x1234 in cycle t+2 only.
REQ-033 Contention: all three requesters push {id=1,2,3} in the same cycle -> broadcasts in order 1, 2, 3 on three consecutive cycles.
REQ-034 Full: req2 pushes 3 times with no pops (rdy_in toggled low after 2) -> _req_full[2]=1 at count 2, third value not queued.
REQ-035 Flush: 2 entries queued per requester, _clear pulsed -> next cycle _cdb_ready=0, all _req_full=0, no stale ids broadcast.
REQ-036 Freeze: rdy_in=0 for 4 cycles mid-stream -> outputs and queues unchanged, sequence resumes intact.
REQ-037 Drop: push with id=0 -> no broadcast, count unchanged.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus (CDB) result arbiter:
// payload widths and the fixed requester indices.
package cdb_arbiter_pkg;

    localparam int ROB_ID_W = 5;
    localparam int VALUE_W  = 32;
    localparam int ENTRY_W  = ROB_ID_W + VALUE_W;

    localparam int REQ_ALU = 0;
    localparam int REQ_BR  = 1;
    localparam int REQ_LS  = 2;

    typedef struct packed {
        logic [ROB_ID_W-1:0] rob_id;
        logic [VALUE_W-1:0]  value;
    } cdb_entry_t;

endpackage

// File: rtl/result_fifo.sv
// Per-requester result queue: QDEPTH entries of {rob_id, value}, with
// push/pop/flush and a registered occupancy count.
module result_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int CW     = $clog2(QDEPTH + 1)
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic [CW-1:0]      count
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    logic [ENTRY_W-1:0] mem [QDEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign dout = mem[rd_ptr];

    // NOTE: storage has no reset; occupancy lives in count/pointers, so stale data is never observed.
    always_ff @(posedge clk_in) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that drains NREQ result queues onto a single registered
// common data bus, one broadcast per cycle.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NREQ   = REQ_LS + 1,
    parameter int QDEPTH = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     _clear,
    input  logic [NREQ-1:0]          _req_valid,
    input  logic [ROB_ID_W*NREQ-1:0] _req_rob_id,
    input  logic [VALUE_W*NREQ-1:0]  _req_value,
    output logic [NREQ-1:0]          _req_full,
    output logic                     _cdb_ready,
    output logic [ROB_ID_W-1:0]      _cdb_rob_id,
    output logic [VALUE_W-1:0]       _cdb_value
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [GW-1:0] LAST_IDX = GW'(NREQ - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

    logic [CW-1:0]      count [NREQ];
    logic [ENTRY_W-1:0] head  [NREQ];
    logic [NREQ-1:0]    push;
    logic [NREQ-1:0]    pop;
    logic [NREQ-1:0]    nonempty;
    logic [GW-1:0]      last_grant;
    logic [GW-1:0]      sel;
    logic               grant;
    logic               flush;
    logic               advance;

    assign flush   = rdy_in && _clear;
    assign advance = rdy_in && !_clear;

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign nonempty[i]  = (count[i] != '0);
        // Full looks only at the registered count, so a same-cycle pop never admits a push.
        assign _req_full[i] = (count[i] == FULL_CNT) || !rdy_in;
        assign push[i]      = _req_valid[i] && !_req_full[i] && !_clear
                              && (_req_rob_id[i*ROB_ID_W +: ROB_ID_W] != '0);
        assign pop[i]       = advance && grant && (sel == GW'(i));

        result_fifo #(
            .QDEPTH (QDEPTH)
        ) u_fifo (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .push   (push[i]),
            .pop    (pop[i]),
            .flush  (flush),
            .din    ({_req_rob_id[i*ROB_ID_W +: ROB_ID_W], _req_value[i*VALUE_W +: VALUE_W]}),
            .dout   (head[i]),
            .count  (count[i])
        );
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        logic [GW:0] cand;
        sel   = last_grant;
        grant = 1'b0;
        cand  = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = {1'b0, last_grant} + (GW+1)'(off);
            if (cand >= (GW+1)'(NREQ)) cand = cand - (GW+1)'(NREQ);
            if (!grant && nonempty[cand[GW-1:0]]) begin
                grant = 1'b1;
                sel   = cand[GW-1:0];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_grant  <= LAST_IDX;
            _cdb_ready  <= 1'b0;
            _cdb_rob_id <= '0;
            _cdb_value  <= '0;
        end else if (rdy_in) begin
            if (_clear) begin
                _cdb_ready <= 1'b0;
                last_grant <= LAST_IDX;
            end else if (grant) begin
                _cdb_ready                 <= 1'b1;
                {_cdb_rob_id, _cdb_value}  <= head[sel];
                last_grant                 <= sel;
            end else begin
                _cdb_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus pushes the predicted broadcast
// order, a negedge monitor pops and compares every consumed CDB broadcast.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NREQ = 3;
    localparam int R    = 4;

    logic                     clk_in;
    logic                     rst_in;
    logic                     rdy_in;
    logic                     clear;
    logic [NREQ-1:0]          req_valid;
    logic [ROB_ID_W*NREQ-1:0] req_rob_id;
    logic [VALUE_W*NREQ-1:0]  req_value;
    logic [NREQ-1:0]          req_full;
    logic                     cdb_ready;
    logic [ROB_ID_W-1:0]      cdb_rob_id;
    logic [VALUE_W-1:0]       cdb_value;

    int         n_cmp = 0;
    int         n_bad = 0;
    cdb_entry_t exp_q[$];
    cdb_entry_t mon_e;
    int         pushed [NREQ];

    cdb_arbiter #(.NREQ(NREQ), .QDEPTH(2)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        ._clear      (clear),
        ._req_valid  (req_valid),
        ._req_rob_id (req_rob_id),
        ._req_value  (req_value),
        ._req_full   (req_full),
        ._cdb_ready  (cdb_ready),
        ._cdb_rob_id (cdb_rob_id),
        ._cdb_value  (cdb_value)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input int r, input logic [4:0] id, input logic [31:0] val);
        req_valid[r]              = 1'b1;
        req_rob_id[r*ROB_ID_W +: ROB_ID_W] = id;
        req_value[r*VALUE_W +: VALUE_W]    = val;
    endtask

    task automatic expect_entry(input logic [4:0] id, input logic [31:0] val);
        cdb_entry_t e;
        e.rob_id = id;
        e.value  = val;
        exp_q.push_back(e);
    endtask

    function automatic logic [4:0] fair_id(input int r, input int n);
        return 5'(r * 8 + n + 1);
    endfunction

    function automatic logic [31:0] fair_val(input int r, input int n);
        return 32'hF000_0000 + 32'(r * 256 + n);
    endfunction

    // A broadcast is consumed at the next edge that has rdy_in high.
    always @(negedge clk_in) begin
        if (!rst_in && rdy_in && cdb_ready) begin
            if (exp_q.size() == 0) begin
                check("cdb_unexpected", 64'(cdb_ready), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("cdb_entry", {cdb_rob_id, cdb_value}, {mon_e.rob_id, mon_e.value});
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        int total;
        rst_in = 1'b1; rdy_in = 1'b0; clear = 1'b0;
        req_valid = '0; req_rob_id = '0; req_value = '0;

        // Reset is honoured even with rdy_in low.
        tick(); tick();
        check("rst_ready", 64'(cdb_ready), 64'd0);
        check("rst_id",    64'(cdb_rob_id), 64'd0);
        check("rst_val",   64'(cdb_value), 64'd0);
        rdy_in = 1'b1;
        tick();
        check("rst_full", 64'(req_full), 64'd0);
        rst_in = 1'b0;

        // Contention right after reset: grant order starts at requester 0.
        set_req(REQ_ALU, 5'd1, 32'h11); set_req(REQ_BR, 5'd2, 32'h22); set_req(REQ_LS, 5'd3, 32'h33);
        expect_entry(5'd1, 32'h11); expect_entry(5'd2, 32'h22); expect_entry(5'd3, 32'h33);
        tick();
        req_valid = '0;
        check("cont_lat", 64'(cdb_ready), 64'd0);
        tick(); check("cont_g0", 64'(cdb_rob_id), 64'd1);
        tick(); check("cont_g1", 64'(cdb_rob_id), 64'd2);
        tick(); check("cont_g2", 64'(cdb_rob_id), 64'd3);
        tick(); check("cont_idle", 64'(cdb_ready), 64'd0);

        // Single uncontended push: visible for exactly one cycle, two edges later.
        set_req(REQ_ALU, 5'd5, 32'h1234);
        expect_entry(5'd5, 32'h1234);
        tick();
        req_valid = '0;
        check("single_early", 64'(cdb_ready), 64'd0);
        tick();
        check("single_ready", 64'(cdb_ready), 64'd1);
        check("single_id",    64'(cdb_rob_id), 64'd5);
        check("single_val",   64'(cdb_value), 64'h1234);
        tick();
        check("single_once", 64'(cdb_ready), 64'd0);

        // Fairness: requesters kept non-empty must rotate 1,2,0,1,2,0...
        for (int k = 0; k < NREQ * R; k++) begin
            expect_entry(fair_id((1 + k) % NREQ, k / NREQ), fair_val((1 + k) % NREQ, k / NREQ));
        end
        for (int r = 0; r < NREQ; r++) pushed[r] = 0;
        total = 0;
        for (int cyc = 0; cyc < 50 && total < NREQ * R; cyc++) begin
            req_valid = '0;
            for (int r = 0; r < NREQ; r++) begin
                if (pushed[r] < R && !req_full[r]) begin
                    set_req(r, fair_id(r, pushed[r]), fair_val(r, pushed[r]));
                    pushed[r]++;
                    total++;
                end
            end
            tick();
        end
        req_valid = '0;
        check("fair_pushed", 64'(total), 64'(NREQ * R));
        repeat (8) tick();
        check("fair_drained", 64'(cdb_ready), 64'd0);

        // Full: requester 2 reaches depth while requester 1 holds the grant.
        set_req(REQ_BR, 5'd20, 32'h2020); set_req(REQ_LS, 5'd21, 32'h2121);
        expect_entry(5'd20, 32'h2020); expect_entry(5'd21, 32'h2121);
        tick();
        req_valid = '0;
        set_req(REQ_LS, 5'd22, 32'h2222);
        expect_entry(5'd22, 32'h2222);
        tick();
        check("full_ls", 64'(req_full), 64'b100);
        check("full_g_id", 64'(cdb_rob_id), 64'd20);
        rdy_in = 1'b0;
        req_valid = '0;
        set_req(REQ_LS, 5'd23, 32'hDEAD);
        tick();
        check("full_rdy_low", 64'(req_full), 64'b111);
        check("full_hold_rdy", 64'(cdb_ready), 64'd1);
        tick();
        check("full_hold_id", 64'(cdb_rob_id), 64'd20);
        rdy_in = 1'b1;
        tick();
        req_valid = '0;
        check("full_pop_id", 64'(cdb_rob_id), 64'd21);
        check("full_after_pop", 64'(req_full), 64'b000);
        tick(); check("full_last_id", 64'(cdb_rob_id), 64'd22);
        tick(); check("full_idle", 64'(cdb_ready), 64'd0);

        // Freeze: rdy_in low for 4 cycles mid-stream.
        set_req(REQ_ALU, 5'd1, 32'hA1); set_req(REQ_BR, 5'd2, 32'hA2); set_req(REQ_LS, 5'd3, 32'hA3);
        expect_entry(5'd1, 32'hA1); expect_entry(5'd2, 32'hA2); expect_entry(5'd3, 32'hA3);
        tick();
        req_valid = '0;
        tick();
        rdy_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("frz_ready", 64'(cdb_ready), 64'd1);
            check("frz_data", {cdb_rob_id, cdb_value}, {5'd1, 32'hA1});
        end
        rdy_in = 1'b1;
        tick(); check("frz_resume1", 64'(cdb_rob_id), 64'd2);
        tick(); check("frz_resume2", 64'(cdb_rob_id), 64'd3);
        tick(); check("frz_idle", 64'(cdb_ready), 64'd0);

        // Flush with queued entries and a same-cycle push.
        set_req(REQ_ALU, 5'd4, 32'hB4); set_req(REQ_BR, 5'd5, 32'hB5); set_req(REQ_LS, 5'd6, 32'hB6);
        tick();
        set_req(REQ_ALU, 5'd7, 32'hB7); set_req(REQ_BR, 5'd8, 32'hB8); set_req(REQ_LS, 5'd9, 32'hB9);
        tick();
        expect_entry(5'd4, 32'hB4);
        req_valid = '0;
        clear = 1'b1;
        set_req(REQ_BR, 5'd13, 32'hBD);
        tick();
        clear = 1'b0;
        req_valid = '0;
        check("flush_ready", 64'(cdb_ready), 64'd0);
        check("flush_full",  64'(req_full), 64'd0);
        repeat (4) tick();
        check("flush_quiet", 64'(cdb_ready), 64'd0);
        set_req(REQ_ALU, 5'd10, 32'hC0); set_req(REQ_BR, 5'd11, 32'hC1); set_req(REQ_LS, 5'd12, 32'hC2);
        expect_entry(5'd10, 32'hC0); expect_entry(5'd11, 32'hC1); expect_entry(5'd12, 32'hC2);
        tick();
        req_valid = '0;
        tick(); check("flush_lg_id", 64'(cdb_rob_id), 64'd10);
        repeat (3) tick();

        // Drop: rob_id 0 is never queued.
        set_req(REQ_ALU, 5'd0, 32'hBAD);
        tick();
        req_valid = '0;
        check("drop_full", 64'(req_full), 64'd0);
        tick(); check("drop_no_bcast", 64'(cdb_ready), 64'd0);
        tick(); check("drop_no_bcast2", 64'(cdb_ready), 64'd0);

        // Reset mid-stream discards queued results.
        set_req(REQ_ALU, 5'd14, 32'hE0); set_req(REQ_BR, 5'd15, 32'hE1); set_req(REQ_LS, 5'd16, 32'hE2);
        tick();
        req_valid = '0;
        rst_in = 1'b1;
        tick();
        check("mrst_ready", 64'(cdb_ready), 64'd0);
        check("mrst_id",    64'(cdb_rob_id), 64'd0);
        check("mrst_val",   64'(cdb_value), 64'd0);
        check("mrst_full",  64'(req_full), 64'd0);
        rst_in = 1'b0;
        repeat (4) tick();
        check("mrst_quiet", 64'(cdb_ready), 64'd0);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
